// File: rtl/i2c_slave_core.sv
// I2C responder engine: synchronises the pad inputs, decodes START/STOP, matches
// SLAVE_ADDR and moves bytes to/from local logic over single-cycle strobes.
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       scl_oen,
  output logic       sda_out,
  output logic       sda_oen,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic [2:0] state_dbg
);

  // Local handshake: wr_valid and rd_req are one-clock strobes with no ready;
  // local logic must accept wr_data on the strobe and settle rd_data before the
  // next SCL fall after rd_req.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6
  } state_t;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  state_t     state_q, state_n;
  logic [2:0] bit_cnt_q, bit_cnt_n;
  logic       sampled_q, sampled_n;
  logic [7:0] shift_q, shift_n;
  logic [7:0] tx_q, tx_n;
  logic       rw_q, rw_n;
  logic       oen_q, oen_n;
  logic       wr_valid_q, wr_valid_n;
  logic [7:0] wr_data_q, wr_data_n;
  logic       rd_req_q, rd_req_n;
  logic       busy_q, busy_n;

  logic scl_rise, scl_fall, start_det, stop_det;

  // Synchronisers reset to the idle bus level so release never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      sampled_q  <= 1'b0;
      shift_q    <= 8'h00;
      tx_q       <= 8'h00;
      rw_q       <= 1'b0;
      oen_q      <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_data_q  <= 8'h00;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      sampled_q  <= sampled_n;
      shift_q    <= shift_n;
      tx_q       <= tx_n;
      rw_q       <= rw_n;
      oen_q      <= oen_n;
      wr_valid_q <= wr_valid_n;
      wr_data_q  <= wr_data_n;
      rd_req_q   <= rd_req_n;
      busy_q     <= busy_n;
    end
  end

  // sampled_q marks that a rise has been seen since the last fall, so the SCL
  // fall that follows a START is not mistaken for the end of a bit.
  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    sampled_n  = sampled_q;
    shift_n    = shift_q;
    tx_n       = tx_q;
    rw_n       = rw_q;
    oen_n      = oen_q;
    wr_valid_n = 1'b0;
    wr_data_n  = wr_data_q;
    rd_req_n   = 1'b0;
    busy_n     = busy_q;

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd0;
      sampled_n = 1'b0;
      oen_n     = 1'b1;
      busy_n    = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = 3'd0;
      sampled_n = 1'b0;
      oen_n     = 1'b1;
      busy_n    = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift_n   = {shift_q[6:0], sda_s2};
            bit_cnt_n = bit_cnt_q + 3'd1;
            sampled_n = 1'b1;
          end else if (scl_fall && sampled_q) begin
            sampled_n = 1'b0;
            if (bit_cnt_q == 3'd0) begin
              if (state_q == ADDR) begin
                if (shift_q[7:1] == SLAVE_ADDR) begin
                  oen_n   = 1'b0;
                  busy_n  = 1'b1;
                  rw_n    = shift_q[0];
                  state_n = ADDR_ACK;
                end else begin
                  state_n = IDLE;
                end
              end else begin
                wr_data_n  = shift_q;
                wr_valid_n = 1'b1;
                oen_n      = 1'b0;
                state_n    = WR_ACK;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            sampled_n = 1'b1;
            rd_req_n  = rw_q;
          end else if (scl_fall && sampled_q) begin
            sampled_n = 1'b0;
            bit_cnt_n = 3'd0;
            if (rw_q) begin
              tx_n    = {rd_data[6:0], 1'b0};
              oen_n   = rd_data[7];
              state_n = RD_DATA;
            end else begin
              oen_n   = 1'b1;
              state_n = WR_DATA;
            end
          end
        end
        WR_ACK: begin
          if (scl_rise) begin
            sampled_n = 1'b1;
          end else if (scl_fall && sampled_q) begin
            sampled_n = 1'b0;
            oen_n     = 1'b1;
            state_n   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt_q + 3'd1;
            sampled_n = 1'b1;
          end else if (scl_fall && sampled_q) begin
            sampled_n = 1'b0;
            if (bit_cnt_q == 3'd0) begin
              oen_n   = 1'b1;
              state_n = RD_ACK;
            end else begin
              oen_n = tx_q[7];
              tx_n  = {tx_q[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              rd_req_n  = 1'b1;
              sampled_n = 1'b1;
            end else begin
              state_n = IDLE;
              oen_n   = 1'b1;
              busy_n  = 1'b0;
            end
          end else if (scl_fall && sampled_q) begin
            sampled_n = 1'b0;
            bit_cnt_n = 3'd0;
            tx_n      = {rd_data[6:0], 1'b0};
            oen_n     = rd_data[7];
            state_n   = RD_DATA;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign scl_out   = 1'b0;
  assign scl_oen   = 1'b1;
  assign sda_out   = 1'b0;
  assign sda_oen   = oen_q;
  assign wr_valid  = wr_valid_q;
  assign wr_data   = wr_data_q;
  assign rd_req    = rd_req_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: a bit-level I2C master with an open-drain
// bus model, plus a scoreboard that checks write strobes and read bytes.
module tb_i2c_slave_core;

  localparam int Q = 8;  // clocks per quarter SCL period

  logic       clk;
  logic       rst_n;
  logic       m_scl, m_sda;
  logic       scl_in, sda_in;
  logic       scl_out, scl_oen, sda_out, sda_oen;
  logic       wr_valid, rd_req, busy;
  logic [7:0] wr_data, rd_data;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_req_cnt = 0;
  int oen_low_cnt = 0;

  logic [7:0] exp_q[$];     // expected wr_data per wr_valid strobe
  logic [7:0] rd_exp_q[$];  // expected bytes seen by the master on reads
  logic [7:0] rd_act_q[$];  // bytes the master actually collected
  logic [7:0] rd_src_q[$];  // bytes served to the DUT on each rd_req

  assign scl_in = m_scl;
  assign sda_in = m_sda & sda_oen;

  i2c_slave_core #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
    .scl_out(scl_out), .scl_oen(scl_oen), .sda_out(sda_out), .sda_oen(sda_oen),
    .wr_valid(wr_valid), .wr_data(wr_data), .rd_req(rd_req), .rd_data(rd_data),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver tasks (SCL low on entry and exit for bit/byte tasks)
  task automatic bit_tx(input logic b, output logic s);
    m_sda = b;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    s = sda_in;
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic do_start();
    m_sda = 1'b1;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    m_sda = 1'b0;
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic do_stop();
    m_sda = 1'b0;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    m_sda = 1'b1;
    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) bit_tx(b[i], s);
    bit_tx(1'b1, s);
    check(name, {31'd0, s}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(input logic ack_bit);
    logic s;
    logic [7:0] v;
    for (int i = 7; i >= 0; i--) begin
      bit_tx(1'b1, s);
      v[i] = s;
    end
    bit_tx(ack_bit, s);
    rd_act_q.push_back(v);
  endtask

  // local-logic model: serve the next read byte on each rd_req strobe
  initial begin
    rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_req && rd_src_q.size() > 0) rd_data = rd_src_q.pop_front();
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rd_req) rd_req_cnt++;
      if (!sda_oen) oen_low_cnt++;
      if (wr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr_valid", {24'd0, wr_data}, 32'hffff_ffff);
        end else begin
          check("wr_data", {24'd0, wr_data}, {24'd0, exp_q.pop_front()});
        end
      end
      while (rd_act_q.size() > 0) begin
        if (rd_exp_q.size() == 0)
          check("unexpected_rd_byte", {24'd0, rd_act_q.pop_front()}, 32'hffff_ffff);
        else
          check("rd_byte", {24'd0, rd_act_q.pop_front()}, {24'd0, rd_exp_q.pop_front()});
      end
    end
  end

  initial begin
    m_scl = 1'b1;
    m_sda = 1'b1;
    rst_n = 1'b0;
    wait_clk(5);
    check("rst_sda_oen", {31'd0, sda_oen}, 32'd1);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_rd_req", {31'd0, rd_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    check("tie_scl_out", {31'd0, scl_out}, 32'd0);
    check("tie_scl_oen", {31'd0, scl_oen}, 32'd1);
    check("tie_sda_out", {31'd0, sda_out}, 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // 1) simple write
    exp_q.push_back(8'h3C);
    do_start();
    write_byte(8'hA0, 1'b0, "t1_addr_ack");
    check("t1_busy_addressed", {31'd0, busy}, 32'd1);
    write_byte(8'h3C, 1'b0, "t1_data_ack");
    do_stop();
    wait_clk(4);
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t1_exp_q_drained", exp_q.size(), 32'd0);

    // 2) wrong address: SDA never pulled
    oen_low_cnt = 0;
    rd_req_cnt  = 0;
    do_start();
    write_byte(8'hA2, 1'b1, "t2_addr_nack");
    write_byte(8'h3C, 1'b1, "t2_data_nack");
    check("t2_busy", {31'd0, busy}, 32'd0);
    do_stop();
    wait_clk(4);
    check("t2_oen_low_cycles", oen_low_cnt, 32'd0);
    check("t2_rd_req_cnt", rd_req_cnt, 32'd0);

    // 3) read two bytes, ACK then NACK
    rd_req_cnt = 0;
    rd_src_q.push_back(8'hA5);
    rd_src_q.push_back(8'h3C);
    rd_exp_q.push_back(8'hA5);
    rd_exp_q.push_back(8'h3C);
    do_start();
    write_byte(8'hA1, 1'b0, "t3_addr_ack");
    read_byte(1'b0);
    read_byte(1'b1);
    wait_clk(2);
    check("t3_state_idle_after_nack", {29'd0, state_dbg}, 32'd0);
    check("t3_busy_after_nack", {31'd0, busy}, 32'd0);
    check("t3_rd_req_cnt", rd_req_cnt, 32'd2);
    do_stop();
    wait_clk(4);

    // 4) repeated start: write 0x11 then read without STOP
    rd_req_cnt = 0;
    exp_q.push_back(8'h11);
    rd_src_q.push_back(8'h96);
    rd_exp_q.push_back(8'h96);
    do_start();
    write_byte(8'hA0, 1'b0, "t4_waddr_ack");
    write_byte(8'h11, 1'b0, "t4_wdata_ack");
    do_start();
    write_byte(8'hA1, 1'b0, "t4_raddr_ack");
    check("t4_busy_readdressed", {31'd0, busy}, 32'd1);
    read_byte(1'b1);
    do_stop();
    wait_clk(4);
    check("t4_rd_req_cnt", rd_req_cnt, 32'd1);

    // 5) reset while the slave drives a 0 data bit
    rd_src_q.push_back(8'h5A);
    do_start();
    write_byte(8'hA1, 1'b0, "t5_addr_ack");
    wait_clk(2);
    check("t5_driving_zero", {31'd0, sda_oen}, 32'd0);
    rst_n = 1'b0;
    wait_clk(1);
    check("t5_rst_sda_oen", {31'd0, sda_oen}, 32'd1);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_state", {29'd0, state_dbg}, 32'd0);
    check("t5_rst_rd_req", {31'd0, rd_req}, 32'd0);
    rst_n = 1'b1;
    m_sda = 1'b1;
    wait_clk(Q);
    exp_q.push_back(8'h77);
    do_start();
    write_byte(8'hA0, 1'b0, "t5_post_addr_ack");
    write_byte(8'h77, 1'b0, "t5_post_data_ack");
    do_stop();
    wait_clk(4);

    // 6) STOP after four data bits: no strobe
    begin
      logic s;
      do_start();
      write_byte(8'hA0, 1'b0, "t6_addr_ack");
      bit_tx(1'b0, s);
      bit_tx(1'b0, s);
      bit_tx(1'b1, s);
      bit_tx(1'b1, s);
      do_stop();
      wait_clk(4);
      check("t6_state_idle", {29'd0, state_dbg}, 32'd0);
      check("t6_sda_oen", {31'd0, sda_oen}, 32'd1);
      check("t6_busy", {31'd0, busy}, 32'd0);
    end

    wait_clk(4);
    check("final_exp_q_empty", exp_q.size(), 32'd0);
    check("final_rd_exp_q_empty", rd_exp_q.size(), 32'd0);
    check("final_rd_src_q_empty", rd_src_q.size(), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
